led_multi_blink: RTL and testbench

Parametrised multi-channel LED driver, generalising the single fixed 1 Hz LED blinker to LED_NUM independent channels. Each channel runs in one of four runtime-selectable modes: OFF, ON, BLINK with a programmable half-period in ms, or 8-bit PWM dimming. A shared 1 ms tick prescaler and a shared PWM counter feed all channels. The block sits between board pins and any control logic (key handler, UART command decoder) that writes channel configuration.

---
 rtl/led_multi_blink_pkg.sv | 14 +
 rtl/led_multi_blink_if.sv | 17 +
 rtl/led_multi_blink_chan.sv | 68 ++++++
 rtl/led_multi_blink.sv | 57 +++++
 tb/tb_led_multi_blink.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_multi_blink_pkg.sv
// Shared definitions for the multi-channel LED driver: channel modes and
// configuration value width.
package led_multi_blink_pkg;

  localparam int VAL_W = 16;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } mode_t;

endpackage

// File: rtl/led_multi_blink_if.sv
// Channel configuration bus shared by the control side and the LED driver.
interface led_multi_blink_if;
  import led_multi_blink_pkg::*;

  // cfg_we is a fire-and-forget strobe with no ready: every cycle it is high
  // is one write, taken at that clock edge. sync is a one-cycle pulse.
  logic             cfg_we;
  logic [3:0]       cfg_ch;
  logic [1:0]       cfg_mode;
  logic [VAL_W-1:0] cfg_val;
  logic             sync;

  modport master (output cfg_we, output cfg_ch, output cfg_mode,
                  output cfg_val, output sync);
  modport slave  (input cfg_we, input cfg_ch, input cfg_mode,
                  input cfg_val, input sync);
endinterface

// File: rtl/led_multi_blink_chan.sv
// One LED channel: holds mode/value, the ms blink counter and phase, and a
// registered lit state (active-high; polarity is applied at the top).
module led_chan
  import led_multi_blink_pkg::*;
#(
  parameter int RST_HALF_MS = 500
) (
  input  logic             Clk50M,
  input  logic             Rst_n,
  input  logic             tick_ms,
  input  logic [7:0]       pwm_cnt,
  input  logic             we,
  input  mode_t            mode,
  input  logic [VAL_W-1:0] val,
  input  logic             sync,
  output logic             lit
);

  mode_t            mode_q;
  logic [VAL_W-1:0] val_q;
  logic [VAL_W-1:0] cnt_q;
  logic             phase_q;
  logic [VAL_W-1:0] half_m1;
  logic             lit_d;

  // A half-period of 0 behaves like 1, so the terminal count is 0 either way.
  assign half_m1 = (val_q == '0) ? '0 : val_q - 1'b1;

  always_ff @(posedge Clk50M or negedge Rst_n) begin
    if (!Rst_n) begin
      mode_q  <= MODE_BLINK;
      val_q   <= VAL_W'(RST_HALF_MS);
      cnt_q   <= '0;
      phase_q <= 1'b0;
      lit     <= 1'b0;
    end else begin
      lit <= lit_d;
      if (we) begin
        mode_q  <= mode;
        val_q   <= val;
        cnt_q   <= '0;
        phase_q <= 1'b0;
      end else if (sync) begin
        cnt_q   <= '0;
        phase_q <= 1'b0;
      end else if (tick_ms && (mode_q == MODE_BLINK)) begin
        if (cnt_q == half_m1) begin
          cnt_q   <= '0;
          phase_q <= ~phase_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    lit_d = 1'b0;
    unique case (mode_q)
      MODE_OFF:   lit_d = 1'b0;
      MODE_ON:    lit_d = 1'b1;
      MODE_BLINK: lit_d = phase_q;
      MODE_PWM:   lit_d = (pwm_cnt < val_q[7:0]);
      default:    lit_d = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_multi_blink.sv
// Multi-channel LED driver: shared 1 ms prescaler and PWM counter feeding
// LED_NUM independent OFF/ON/BLINK/PWM channels.
module led_multi_blink
  import led_multi_blink_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int LED_NUM     = 4,
  parameter int RST_HALF_MS = 500,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic               Clk50M,
  input  logic               Rst_n,
  led_multi_blink_if.slave   cfg,
  output logic               tick_ms,
  output logic [LED_NUM-1:0] led
);

  localparam int DIV = CLK_FREQ / 1000;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_TERM = PW'(DIV - 1);

  logic [PW-1:0]      presc;
  logic [7:0]         pwm_cnt;
  logic [LED_NUM-1:0] lit_vec;

  always_ff @(posedge Clk50M or negedge Rst_n) begin
    if (!Rst_n) begin
      presc   <= '0;
      pwm_cnt <= '0;
      tick_ms <= 1'b0;
    end else begin
      presc   <= (presc == PRESC_TERM) ? '0 : presc + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
      tick_ms <= (presc == PRESC_TERM);
    end
  end

  // Indices at or above LED_NUM match no channel, so such writes vanish.
  for (genvar i = 0; i < LED_NUM; i++) begin : g_chan
    led_chan #(
      .RST_HALF_MS(RST_HALF_MS)
    ) u_chan (
      .Clk50M  (Clk50M),
      .Rst_n   (Rst_n),
      .tick_ms (tick_ms),
      .pwm_cnt (pwm_cnt),
      .we      (cfg.cfg_we && (cfg.cfg_ch == 4'(i))),
      .mode    (mode_t'(cfg.cfg_mode)),
      .val     (cfg.cfg_val),
      .sync    (cfg.sync),
      .lit     (lit_vec[i])
    );
  end

  assign led = (ACTIVE_LOW != 0) ? ~lit_vec : lit_vec;

endmodule

// File: tb/tb_led_multi_blink.sv
// Bench for led_multi_blink: directed scenarios plus random config traffic,
// checked every cycle against a tick-counting behavioural model.
module tb_led_multi_blink;
  import led_multi_blink_pkg::*;

  localparam int CLK_FREQ = 10_000;
  localparam int LED_NUM  = 4;
  localparam int RST_HALF = 500;
  localparam int DIV      = CLK_FREQ / 1000;

  logic               Clk50M;
  logic               Rst_n;
  logic               tick_ms;
  logic [LED_NUM-1:0] led;

  led_multi_blink_if cfg_bus ();

  led_multi_blink #(
    .CLK_FREQ(CLK_FREQ), .LED_NUM(LED_NUM),
    .RST_HALF_MS(RST_HALF), .ACTIVE_LOW(1)
  ) dut (
    .Clk50M (Clk50M),
    .Rst_n  (Rst_n),
    .cfg    (cfg_bus),
    .tick_ms(tick_ms),
    .led    (led)
  );

  // ---------------- clock / reset ----------------
  initial Clk50M = 1'b0;
  always #5 Clk50M = ~Clk50M;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- behavioural model ----------------
  // Per channel: mode, value and number of ms ticks counted since the last
  // restart; the blink phase is simply (ticks / H) odd.
  int               m_mode [LED_NUM];
  int               m_val  [LED_NUM];
  int               m_ticks[LED_NUM];
  int               n;
  logic [LED_NUM-1:0] exp_led;
  logic             exp_tick;

  function automatic logic model_lit(int c, int edge_n);
    int h;
    h = (m_val[c] == 0) ? 1 : m_val[c];
    case (m_mode[c])
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ((m_ticks[c] / h) % 2) == 1;
      default: return (edge_n % 256) < (m_val[c] % 256);
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < LED_NUM; c++) begin
      m_mode[c]  = 2;
      m_val[c]   = RST_HALF;
      m_ticks[c] = 0;
    end
    n        = 0;
    exp_led  = '1;
    exp_tick = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge Clk50M or negedge Rst_n);
      if (!Rst_n) begin
        model_reset();
      end else begin
        logic tick_now;
        logic [LED_NUM-1:0] lit;
        tick_now = (n > 0) && (n % DIV == 0);
        for (int c = 0; c < LED_NUM; c++) lit[c] = model_lit(c, n);
        exp_led  = ~lit;
        exp_tick = (n % DIV == DIV - 1);
        for (int c = 0; c < LED_NUM; c++) begin
          if (cfg_bus.cfg_we && int'(cfg_bus.cfg_ch) == c) begin
            m_mode[c]  = int'(cfg_bus.cfg_mode);
            m_val[c]   = int'(cfg_bus.cfg_val);
            m_ticks[c] = 0;
          end else if (cfg_bus.sync) begin
            m_ticks[c] = 0;
          end else if (tick_now && m_mode[c] == 2) begin
            m_ticks[c]++;
          end
        end
        n++;
      end
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  initial begin
    forever begin
      @(negedge Clk50M);
      n_vec++;
      if (led !== exp_led || tick_ms !== exp_tick) begin
        n_err++;
        $display("FAIL cycle_cmp: led=%b tick=%b exp led=%b tick=%b (n=%0d)",
                 led, tick_ms, exp_led, exp_tick, n);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int got, input int exp_v);
    n_vec++;
    if (got != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d exp %0d", name, got, exp_v);
    end
  endtask

  task automatic run(input int k);
    repeat (k) @(negedge Clk50M);
  endtask

  task automatic write_cfg(input int ch, input int mode, input int val,
                           input bit with_sync = 1'b0);
    @(negedge Clk50M);
    cfg_bus.cfg_we   = 1'b1;
    cfg_bus.cfg_ch   = 4'(ch);
    cfg_bus.cfg_mode = 2'(mode);
    cfg_bus.cfg_val  = 16'(val);
    cfg_bus.sync     = with_sync;
    @(negedge Clk50M);
    cfg_bus.cfg_we = 1'b0;
    cfg_bus.sync   = 1'b0;
  endtask

  task automatic pulse_sync();
    @(negedge Clk50M);
    cfg_bus.sync = 1'b1;
    @(negedge Clk50M);
    cfg_bus.sync = 1'b0;
  endtask

  function automatic int count_bit_toggles(input logic a, input logic b);
    return (a != b) ? 1 : 0;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    int ok;
    logic p1, p2;
    Rst_n            = 1'b0;
    cfg_bus.cfg_we   = 1'b0;
    cfg_bus.cfg_ch   = '0;
    cfg_bus.cfg_mode = '0;
    cfg_bus.cfg_val  = '0;
    cfg_bus.sync     = 1'b0;

    // Reset state
    run(3);
    chk("rst_led", int'(led), 15);
    chk("rst_tick", int'(tick_ms), 0);
    Rst_n = 1'b1;

    // Default 500 ms blink: dark until tick 500 (edge 5000), lit after 5001
    run(5001);
    chk("dflt_dark_5000", int'(led), 15);
    run(1);
    chk("dflt_lit_5001", int'(led), 0);
    run(4999);
    chk("dflt_lit_10000", int'(led), 0);
    run(1);
    chk("dflt_dark_10001", int'(led), 15);

    // ch1 BLINK 3, ch2 BLINK 0: 30 ticks -> 10 and 30 toggles
    write_cfg(1, 2, 3);
    write_cfg(2, 2, 0);
    run(2);
    p1 = led[1]; p2 = led[2];
    cnt = 0; ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk50M);
      cnt += count_bit_toggles(p1, led[1]);
      ok  += count_bit_toggles(p2, led[2]);
      p1 = led[1]; p2 = led[2];
    end
    chk("ch1_toggles", cnt, 10);
    chk("ch2_toggles", ok, 30);

    // PWM: upper byte of value ignored, duty 0x40
    write_cfg(0, 3, 16'hAB40);
    run(1);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge Clk50M);
      if (led[0] == 1'b0) cnt++;
    end
    chk("pwm64_lit", cnt, 64);
    write_cfg(0, 3, 0);
    run(1);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge Clk50M);
      if (led[0] == 1'b0) cnt++;
    end
    chk("pwm0_lit", cnt, 0);
    write_cfg(0, 1, 0);
    run(1);
    chk("on_after_1clk", int'(led[0]), 0);

    // Out-of-range channel write, then sync makes equal-H channels lockstep
    write_cfg(7, 1, 5);
    write_cfg(0, 2, 3);
    write_cfg(3, 2, 3);
    run($urandom_range(0, 25));
    pulse_sync();
    ok = 1;
    cnt = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge Clk50M);
      if (!(led[0] == led[1] && led[1] == led[3])) ok = 0;
      if (led[0] == 1'b0) cnt++;
    end
    chk("sync_lockstep", ok, 1);
    chk("sync_lit_cycles", (cnt > 0) ? 1 : 0, 1);

    // Random config traffic, checked by the every-cycle compare
    for (int it = 0; it < 150; it++) begin
      int sel, ch, md, vl;
      run($urandom_range(0, 30));
      sel = $urandom_range(0, 11);
      ch  = $urandom_range(0, 7);
      md  = $urandom_range(0, 3);
      vl  = (md == 2) ? $urandom_range(0, 6) : $urandom_range(0, 65535);
      if (sel < 10)       write_cfg(ch, md, vl);
      else if (sel == 10) pulse_sync();
      else                write_cfg(ch, md, vl, 1'b1);
    end

    // Async reset while ch1 is lit
    write_cfg(1, 2, 3);
    cnt = 0;
    while (led[1] != 1'b0 && cnt < 400) begin
      @(negedge Clk50M);
      cnt++;
    end
    chk("wait_lit_bound", (cnt < 400) ? 1 : 0, 1);
    #2 Rst_n = 1'b0;
    #1;
    chk("async_rst_led", int'(led), 15);
    chk("async_rst_tick", int'(tick_ms), 0);
    @(negedge Clk50M);
    Rst_n = 1'b1;
    run(5001);
    chk("resume_dark_5000", int'(led), 15);
    run(1);
    chk("resume_lit_5001", int'(led), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
